aes_round_core: RTL and testbench

AES_ROUND_CORE -- requirements
Module: aes_round_core

---
 rtl/aes_round_core.sv | 92 +++++++++
 tb/tb_aes_round_core.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_core.sv
// aes_round_core
//   One AES encryption round minus SubBytes:
//   ShiftRows -> MixColumns (bypassed on the final round) -> AddRoundKey -> register.
//   Byte i of a 128-bit state sits at bits [127-8i -: 8], column-major
//   (row i%4, column i/4).
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   in_valid     : capture state_in/round_key/final_round on this edge
//   state_in     : state after SubBytes
//   round_key    : round key, same byte order as state_in
//   final_round  : 1 = skip MixColumns
//   out_valid    : registered, high the cycle after a captured in_valid
//   state_out    : registered round result (holds when in_valid is low)
//   shift_tap    : combinational ShiftRows(state_in)
//   mix_tap      : combinational MixColumns(shift_tap), never bypassed
module aes_round_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic         out_valid,
  output logic [127:0] state_out,
  output logic [127:0] shift_tap,
  output logic [127:0] mix_tap
);

  // GF(2^8) multiply by 2 modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]   in_b [16];
  logic [7:0]   sh_b [16];
  logic [7:0]   mx_b [16];
  logic [127:0] round_result;

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      in_b[i] = state_in[8*(15-i) +: 8];
    end
  end

  // Row r rotates left by r: output column c takes input column (c+r)%4.
  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sh_b[4*c+r] = in_b[4*((c+r)%4)+r];
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < 4; c++) begin
      mx_b[4*c+0] = xtime(sh_b[4*c+0]) ^ xtime(sh_b[4*c+1]) ^ sh_b[4*c+1]
                  ^ sh_b[4*c+2] ^ sh_b[4*c+3];
      mx_b[4*c+1] = sh_b[4*c+0] ^ xtime(sh_b[4*c+1]) ^ xtime(sh_b[4*c+2])
                  ^ sh_b[4*c+2] ^ sh_b[4*c+3];
      mx_b[4*c+2] = sh_b[4*c+0] ^ sh_b[4*c+1] ^ xtime(sh_b[4*c+2])
                  ^ xtime(sh_b[4*c+3]) ^ sh_b[4*c+3];
      mx_b[4*c+3] = xtime(sh_b[4*c+0]) ^ sh_b[4*c+0] ^ sh_b[4*c+1]
                  ^ sh_b[4*c+2] ^ xtime(sh_b[4*c+3]);
    end
  end

  always_comb begin
    shift_tap = '0;
    mix_tap   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      shift_tap[8*(15-i) +: 8] = sh_b[i];
      mix_tap[8*(15-i) +: 8]   = mx_b[i];
    end
  end

  always_comb begin
    round_result = (final_round ? shift_tap : mix_tap) ^ round_key;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        state_out <= round_result;
      end
    end
  end

endmodule

// File: tb/tb_aes_round_core.sv
// tb_aes_round_core
//   Scoreboard bench for aes_round_core. Stimulus drives inputs on the falling
//   edge and pushes the expected round result into a queue; a monitor on the
//   falling edge pops and compares whenever out_valid is high, and checks the
//   held value whenever it is low.
module tb_aes_round_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         final_round;
  logic         out_valid;
  logic [127:0] state_out;
  logic [127:0] shift_tap;
  logic [127:0] mix_tap;

  aes_round_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .state_in    (state_in),
    .round_key   (round_key),
    .final_round (final_round),
    .out_valid   (out_valid),
    .state_out   (state_out),
    .shift_tap   (shift_tap),
    .mix_tap     (mix_tap)
  );

  always #5 clk = ~clk;

  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;
  logic [127:0] exp_q [$];
  logic [127:0] exp_state = '0;
  logic         exp_valid = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model (byte arrays, generic GF multiply) ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] s);
    logic [7:0] b [16];
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = b[4*((c+r)%4)+r];
    return o;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] s);
    logic [7:0] coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [127:0] o = '0;
    logic [7:0] acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k-r+4)%4], s[127-8*(4*c+k) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] k,
                                           input logic f);
    return (f ? m_shift(s) : m_mix(m_shift(s))) ^ k;
  endfunction

  // ---------------- stimulus helpers --------------------------------------
  // Drive one cycle on the falling edge; check taps against the model; push
  // expected result (the supplied constant when use_kat) if valid.
  task automatic drive(input logic v, input logic [127:0] s, input logic [127:0] k,
                       input logic f, input logic use_kat, input logic [127:0] kat);
    @(negedge clk);
    in_valid    = v;
    state_in    = s;
    round_key   = k;
    final_round = f;
    if (v) exp_q.push_back(use_kat ? kat : m_round(s, k, f));
    #1;
    check("shift_tap", shift_tap, m_shift(s));
    check("mix_tap", mix_tap, m_mix(m_shift(s)));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected out_valid for the coming falling edge, from the stimulus itself.
  always @(posedge clk) exp_valid = rst_n && in_valid;

  // ---------------- monitor ------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", {127'b0, out_valid}, {127'b0, exp_valid});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", state_out, 128'hx);
        end else begin
          exp_state = exp_q.pop_front();
          check("state_out", state_out, exp_state);
        end
      end else begin
        check("state_hold", state_out, exp_state);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

  // ---------------- main sequence -----------------------------------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b1; state_in = '1; round_key = '1; final_round = 1'b0;
    #2;
    check("reset_state_out", state_out, '0);
    check("reset_out_valid", {127'b0, out_valid}, '0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 C.1 round 1
    drive(1'b1, 128'h63cab7040953d051cd60e0e7ba70e18c, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
          1'b0, 1'b1, 128'h89d810e8855ace682d1843d8cb128fe4);
    check("kat_shift", shift_tap, 128'h6353e08c0960e104cd70b751bacad0e7);
    check("kat_mix", mix_tap, 128'h5f72641557f5bc92f7be3b291db9f91a);

    // MixColumns known answers
    drive(1'b1, {4{32'hdb135345}}, '0, 1'b0, 1'b1, {4{32'h8e4da1bc}});
    drive(1'b1, {4{32'hf20a225c}}, '0, 1'b0, 1'b1, {4{32'h9fdc589d}});
    drive(1'b1, {4{32'h01010101}}, '0, 1'b0, 1'b1, {4{32'h01010101}});

    // Final round: output equals key, mix_tap still computed (zero here)
    drive(1'b1, '0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b1,
          128'h000102030405060708090a0b0c0d0e0f);
    check("final_mix_tap", mix_tap, '0);

    // Hold: one beat then three idle cycles with changing state_in
    drive(1'b1, rnd128(), rnd128(), 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b0, rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'b0, '0);

    // Async reset mid-cycle while out_valid is high; in-flight beat discarded
    drive(1'b1, rnd128(), rnd128(), 1'b0, 1'b0, '0);
    drive(1'b1, rnd128(), rnd128(), 1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_state = '0;
    #1;
    check("async_state_out", state_out, '0);
    check("async_out_valid", {127'b0, out_valid}, '0);
    @(negedge clk);
    in_valid = 1'b1; state_in = rnd128();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Random back-to-back
    for (int i = 0; i < 1000; i++)
      drive(1'b1, rnd128(), rnd128(), ($urandom_range(0, 3) == 0), 1'b0, '0);
    // Random with gaps
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'b0, '0);

    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
